// File: rtl/decrypt_keyexp_pipe.sv
// decrypt_keyexp_pipe: three-stage packet decryptor, plain = cipher - key(seed).
// Key repeats seed segments as {~s,~s,s,s} from LSB upwards, truncated to CIPH_W.
// Ports: Clk, Rst_n (async, active low); in_valid/in_ready/in_pkt {seed,cipher,tag};
//        out_valid/out_ready/out_plain/out_tag; pkt_cnt (delivered, wraps); out_err.
// Option: define DEC_CHK_EN to add the XOR-fold checksum (out_err, internal err_cnt_q);
//         without it out_err is tied 0 and latency is unchanged.
module decrypt_keyexp_pipe #(
   parameter int SEED_W = 11,
   parameter int CIPH_W = 61,
   parameter int TAG_W  = 6,
   parameter int CNT_W  = 16
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SEED_W+CIPH_W+TAG_W-1:0] in_pkt,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CIPH_W-1:0]              out_plain,
   output logic [TAG_W-1:0]               out_tag,
   output logic [CNT_W-1:0]               pkt_cnt,
   output logic                           out_err
);
   localparam int PKT_W = SEED_W + CIPH_W + TAG_W;
   localparam int NREP  = (CIPH_W + 4 * SEED_W - 1) / (4 * SEED_W);

   logic              adv;
   logic [CIPH_W-1:0] key;
   logic [CIPH_W-1:0] diff;

   logic              s1_vld_q, s1_vld_d;
   logic [SEED_W-1:0] s1_seed_q, s1_seed_d;
   logic [CIPH_W-1:0] s1_ciph_q, s1_ciph_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

   logic              s2_vld_q, s2_vld_d;
   logic [CIPH_W-1:0] s2_key_q, s2_key_d;
   logic [CIPH_W-1:0] s2_ciph_q, s2_ciph_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

   logic              out_valid_q, out_valid_d;
   logic [CIPH_W-1:0] out_plain_q, out_plain_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

   // Segment pattern per group of four: seed, seed, ~seed, ~seed (LSB first).
   assign key  = CIPH_W'({NREP{~s1_seed_q, ~s1_seed_q, s1_seed_q, s1_seed_q}});
   // Borrow is dropped: the subtract wraps modulo 2^CIPH_W.
   assign diff = s2_ciph_q - s2_key_q;

   assign adv = !out_valid_q || out_ready;

   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_seed_d   = s1_seed_q;
      s1_ciph_d   = s1_ciph_q;
      s1_tag_d    = s1_tag_q;
      s2_vld_d    = s2_vld_q;
      s2_key_d    = s2_key_q;
      s2_ciph_d   = s2_ciph_q;
      s2_tag_d    = s2_tag_q;
      out_valid_d = out_valid_q;
      out_plain_d = out_plain_q;
      out_tag_d   = out_tag_q;
      pkt_cnt_d   = pkt_cnt_q;
      if (adv) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_seed_d = in_pkt[PKT_W-1 -: SEED_W];
            s1_ciph_d = in_pkt[TAG_W +: CIPH_W];
            s1_tag_d  = in_pkt[TAG_W-1:0];
         end
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_key_d  = key;
            s2_ciph_d = s1_ciph_q;
            s2_tag_d  = s1_tag_q;
         end
         out_valid_d = s2_vld_q;
         if (s2_vld_q) begin
            out_plain_d = diff;
            out_tag_d   = s2_tag_q;
         end
      end
      if (out_valid_q && out_ready) begin
         pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_seed_q   <= '0;
         s1_ciph_q   <= '0;
         s1_tag_q    <= '0;
         s2_vld_q    <= 1'b0;
         s2_key_q    <= '0;
         s2_ciph_q   <= '0;
         s2_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_plain_q <= '0;
         out_tag_q   <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_seed_q   <= s1_seed_d;
         s1_ciph_q   <= s1_ciph_d;
         s1_tag_q    <= s1_tag_d;
         s2_vld_q    <= s2_vld_d;
         s2_key_q    <= s2_key_d;
         s2_ciph_q   <= s2_ciph_d;
         s2_tag_q    <= s2_tag_d;
         out_valid_q <= out_valid_d;
         out_plain_q <= out_plain_d;
         out_tag_q   <= out_tag_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_plain = out_plain_q;
   assign out_tag   = out_tag_q;
   assign pkt_cnt   = pkt_cnt_q;

`ifdef DEC_CHK_EN
   localparam int NCH  = (CIPH_W + TAG_W - 1) / TAG_W;
   localparam int PADW = NCH * TAG_W;

   logic [PADW-1:0]  pad;
   logic [TAG_W-1:0] chk;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Fold the plaintext TAG_W bits at a time; the top chunk is zero-padded.
   always_comb begin
      pad = PADW'(diff);
      chk = '0;
      for (int i = 0; i < NCH; i++) begin
         chk = chk ^ pad[i*TAG_W +: TAG_W];
      end
      out_err_d = out_err_q;
      err_cnt_d = err_cnt_q;
      if (adv && s2_vld_q) begin
         out_err_d = (chk != s2_tag_q);
      end
      if (out_valid_q && out_ready && out_err_q) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         out_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         out_err_q <= out_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_err = out_err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_decrypt_keyexp_pipe.sv
// tb_decrypt_keyexp_pipe: randomized bench for decrypt_keyexp_pipe with a
// queue-based reference model; directed vectors, stalls, reset mid-stream.
module tb_decrypt_keyexp_pipe;
   localparam int SEED_W = 11;
   localparam int CIPH_W = 61;
   localparam int TAG_W  = 6;
   localparam int CNT_W  = 5;
   localparam int PKT_W  = SEED_W + CIPH_W + TAG_W;

   logic              Clk = 1'b0;
   logic              Rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [PKT_W-1:0]  in_pkt = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CIPH_W-1:0] out_plain;
   logic [TAG_W-1:0]  out_tag;
   logic [CNT_W-1:0]  pkt_cnt;
   logic              out_err;

   decrypt_keyexp_pipe #(
      .SEED_W(SEED_W), .CIPH_W(CIPH_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_plain(out_plain), .out_tag(out_tag),
      .pkt_cnt(pkt_cnt), .out_err(out_err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [CIPH_W-1:0] plain;
      logic [TAG_W-1:0]  tag;
      int                acc;
   } exp_t;

   exp_t              q[$];
   int                total = 0;
   int                bad = 0;
   int                cyc = 0;
   int                exp_cnt = 0;
   int                exp_err = 0;
   int                n_out = 0;
   bit                lat_mode = 1'b1;
   bit                prev_stall = 1'b0;
   logic [CIPH_W-1:0] hold_plain;
   logic [TAG_W-1:0]  hold_tag;

   task automatic chk_eq(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [CIPH_W-1:0] key_of(input logic [SEED_W-1:0] s);
      logic [CIPH_W-1:0] k;
      for (int b = 0; b < CIPH_W; b++) begin
         k[b] = s[b % SEED_W] ^ (((b / SEED_W) % 4) >= 2);
      end
      return k;
   endfunction

   function automatic logic [TAG_W-1:0] fold(input logic [CIPH_W-1:0] p);
      logic [TAG_W-1:0] c;
      c = '0;
      for (int b = 0; b < CIPH_W; b++) begin
         c[b % TAG_W] = c[b % TAG_W] ^ p[b];
      end
      return c;
   endfunction

   function automatic logic [PKT_W-1:0] rnd_pkt();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[PKT_W-1:0];
   endfunction

   function automatic logic [PKT_W-1:0] mk(input logic [SEED_W-1:0] s,
                                           input logic [CIPH_W-1:0] c,
                                           input logic [TAG_W-1:0] t);
      return {s, c, t};
   endfunction

   task automatic step(input bit v, input logic [PKT_W-1:0] p,
                       input bit r, output bit acc);
      exp_t e;
      bit   err;
      @(negedge Clk);
      in_valid  = v;
      in_pkt    = p;
      out_ready = r;
      #1;
      chk_eq("in_ready", in_ready, !out_valid || out_ready);
      chk_eq("pkt_cnt", pkt_cnt, exp_cnt);
`ifdef DEC_CHK_EN
      chk_eq("err_cnt", dut.err_cnt_q, exp_err);
`endif
      if (prev_stall) begin
         chk_eq("hold_valid", out_valid, 1);
         chk_eq("hold_plain", out_plain, hold_plain);
         chk_eq("hold_tag", out_tag, hold_tag);
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            chk_eq("spurious_out", 1, 0);
         end else begin
            e = q.pop_front();
            chk_eq("plain", out_plain, e.plain);
            chk_eq("tag", out_tag, e.tag);
            if (lat_mode) chk_eq("latency", cyc - e.acc, 3);
`ifdef DEC_CHK_EN
            err = (fold(e.plain) != e.tag);
            chk_eq("out_err", out_err, err);
            if (err) exp_err = (exp_err + 1) % (1 << 16);
`else
            err = 1'b0;
            chk_eq("out_err", out_err, err);
`endif
         end
         exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
      prev_stall = out_valid && !out_ready;
      hold_plain = out_plain;
      hold_tag   = out_tag;
      acc = in_valid && in_ready;
      if (acc) begin
         e.plain = p[TAG_W +: CIPH_W] - key_of(p[PKT_W-1 -: SEED_W]);
         e.tag   = p[TAG_W-1:0];
         e.acc   = cyc;
         q.push_back(e);
      end
      cyc++;
   endtask

   task automatic send_dir(input logic [PKT_W-1:0] p,
                           input logic [CIPH_W-1:0] want, input string tag);
      bit a;
      step(1'b1, p, 1'b1, a);
      chk_eq(tag, a, 1);
      if (a) chk_eq({tag, "_model"}, q[$].plain, want);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
   endtask

   initial begin
      bit               a;
      bit               v;
      bit               r;
      bit               pend;
      int               base;
      logic [PKT_W-1:0] p;

      repeat (2) @(negedge Clk);
      #1;
      chk_eq("rst_valid", out_valid, 0);
      chk_eq("rst_plain", out_plain, 0);
      chk_eq("rst_tag", out_tag, 0);
      chk_eq("rst_cnt", pkt_cnt, 0);
      chk_eq("rst_err", out_err, 0);
      @(negedge Clk);
      Rst_n = 1'b1;

      lat_mode = 1'b1;
      send_dir(mk(11'h0, 61'h00000FFFFFC00000, 6'h15), 61'h0, "t1");
      idle(4);
      chk_eq("t1_cnt", pkt_cnt, 1);
      send_dir(mk(11'h0, 61'h0, 6'h2A), 61'h1FFFF00000400000, "t2");
      send_dir(mk(11'h7FF, 61'h1FFFF000003FFFFF, 6'h00), 61'h0, "t3");
      for (int i = 0; i < 8; i++) begin
         step(1'b1, rnd_pkt(), 1'b1, a);
         chk_eq("t3_accept", a, 1);
      end
      idle(4);
      send_dir(mk(11'h0, 61'h00000FFFFFC00000, 6'h00), 61'h0, "t6a");
      send_dir(mk(11'h0, 61'h00000FFFFFC00000, 6'h01), 61'h0, "t6b");
      idle(5);
      chk_eq("dir_drained", q.size(), 0);

      for (int i = 0; i < 3; i++) step(1'b1, rnd_pkt(), 1'b1, a);
      step(1'b0, '0, 1'b0, a);
      chk_eq("pre_rst_valid", out_valid, 1);
      @(negedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_valid", out_valid, 0);
      chk_eq("mid_rst_cnt", pkt_cnt, 0);
      chk_eq("mid_rst_err", out_err, 0);
      q.delete();
      exp_cnt    = 0;
      exp_err    = 0;
      prev_stall = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      cyc++;
      cyc++;
      base = n_out;
      send_dir(mk(11'h155, 61'h0123456789ABCDE, 6'h3F),
               61'h0123456789ABCDE - key_of(11'h155), "post_rst");
      idle(6);
      chk_eq("post_rst_outs", n_out - base, 1);

      lat_mode = 1'b0;
      pend = 1'b0;
      p = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            v = ($urandom_range(0, 3) != 0);
            p = rnd_pkt();
            if ($urandom_range(0, 7) == 0) begin
               p[TAG_W +: CIPH_W] = key_of(p[PKT_W-1 -: SEED_W]);
            end
         end else begin
            v = 1'b1;
         end
         r = (i >= 100 && i < 104) ? 1'b0 : ($urandom_range(0, 9) < 7);
         step(v, p, r, a);
         pend = v && !a;
      end

      for (int i = 0; i < 30; i++) begin
         if (q.size() != 0 || out_valid) step(1'b0, '0, 1'b1, a);
      end
      chk_eq("final_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
